// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared types and helpers for the frame accumulator.
//   acc_state_e : FSM state encoding (idle, accumulating, holding a result).
//   acc_max()   : largest value of a signed two's-complement field of given width.
//   acc_min()   : smallest value of a signed two's-complement field of given width.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } acc_state_e;

  function automatic longint acc_max(input int unsigned width);
    return (longint'(1) << (width - 1)) - 64'sd1;
  endfunction

  function automatic longint acc_min(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add: combinational W-bit signed saturating adder.
//   a, b  : signed W-bit operands.
//   sum   : a + b, clamped to the signed W-bit range.
//   clamp : high when the true sum fell outside the range and was clamped.
module sat_add
  import sum_acc_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                clamp
);

  localparam logic signed [W:0] MaxExt = (W + 1)'(acc_max(W));
  localparam logic signed [W:0] MinExt = (W + 1)'(acc_min(W));

  // One guard bit is enough to hold any sum of two W-bit signed values.
  logic signed [W:0] wide;
  assign wide = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    sum   = wide[W-1:0];
    clamp = 1'b0;
    if (wide > MaxExt) begin
      sum   = MaxExt[W-1:0];
      clamp = 1'b1;
    end else if (wide < MinExt) begin
      sum   = MinExt[W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: frame-based saturating accumulator for the adder's sum stream.
//   clk, rstN            : rising-edge clock, synchronous active-low reset.
//   in_valid/in_ready    : sample handshake; in_data is the signed N-bit sample.
//   len                  : samples per frame, latched on a frame's first transfer (0 means 1).
//   out_valid/out_ready  : result handshake; out_data is the saturated frame sum,
//                          out_sat flags that at least one addition clamped.
// All outputs are decoded from registered state only.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  input  logic        [CNT_W-1:0] len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned ExtW = ACC_W - N;

  acc_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [CNT_W-1:0] len_q, len_d;
  logic                    sat_q, sat_d;

  logic                    in_xfer;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_clamp;
  logic        [CNT_W-1:0] cnt_inc;

  assign in_ext  = {{ExtW{in_data[N-1]}}, in_data};
  assign in_xfer = in_valid && in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  sat_add #(
    .W(ACC_W)
  ) u_sat_add (
    .a    (acc_q),
    .b    (in_ext),
    .sum  (add_sum),
    .clamp(add_clamp)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          len_d   = (len == '0) ? CNT_W'(1) : len;
          acc_d   = in_ext;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
          state_d = (len_d == CNT_W'(1)) ? StHold : StAccum;
        end
      end
      StAccum: begin
        // Only the latched frame length matters here; len is ignored mid-frame.
        if (in_xfer) begin
          acc_d = add_sum;
          sat_d = sat_q | add_clamp;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // The next frame's first sample is taken in idle, one cycle after handoff.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= CNT_W'(1);
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed frames push their hand-computed
// results into a queue; a monitor pops and compares on every result handoff.
module tb_sum_accumulator;

  localparam int unsigned N     = 8;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned CNT_W = 4;

  logic                    clk       = 1'b0;
  logic                    rstN      = 1'b0;
  logic                    in_valid  = 1'b0;
  logic                    out_ready = 1'b1;
  logic signed [N-1:0]     in_data   = '0;
  logic        [CNT_W-1:0] len       = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_sat;

  typedef struct packed {
    logic signed [ACC_W-1:0] data;
    logic                    sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sum_accumulator #(
    .N    (N),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .len      (len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input bit s);
    exp_t e;
    e.data = ACC_W'(d);
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  // Holds the sample on the bus until it is transferred; returns 1 time unit
  // after the transferring edge.
  task automatic send(input int d, input int l);
    bit took;
    took     = 1'b0;
    in_valid = 1'b1;
    in_data  = N'(d);
    len      = CNT_W'(l);
    for (int g = 0; g < 50 && !took; g++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) check("send_accept", took, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_in_ready();
    for (int g = 0; g < 50 && !in_ready; g++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) check("wait_in_ready", in_ready, 1);
  endtask

  // Scoreboard monitor: a handoff happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("result_queue_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", out_data, e.data);
        check("frame_sat", out_sat, e.sat);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // 1 + 2 - 3 = 0, valid the cycle after the third transfer
    push(0, 1'b0);
    send(1, 3);
    check("t1_no_early_valid", out_valid, 0);
    send(2, 3);
    send(-3, 3);
    check("t1_latency", out_valid, 1);

    // Positive and negative saturation at ACC_W=10
    push(511, 1'b1);
    repeat (5) send(127, 5);
    push(-512, 1'b1);
    repeat (5) send(-128, 5);

    // Clamped value keeps accumulating, flag stays sticky: 511 - 128 = 383
    push(383, 1'b1);
    repeat (5) send(127, 6);
    send(-128, 6);

    // len=0 acts as a single-sample frame
    push(-5, 1'b0);
    send(-5, 0);
    check("len0_latency", out_valid, 1);
    check("len0_data", out_data, -5);

    // Output stall: held result, no acceptance until after handoff
    wait_in_ready();
    out_ready = 1'b0;
    push(9, 1'b0);
    push(7, 1'b0);
    send(9, 1);
    check("stall_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = N'(7);
    len      = CNT_W'(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_data", out_data, 9);
      check("stall_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("after_handoff_valid", out_valid, 0);
    check("after_handoff_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_frame_valid", out_valid, 1);

    // Mid-frame len change ignored: 10+20+30+40 = 100
    push(100, 1'b0);
    send(10, 4);
    send(20, 4);
    send(30, 2);
    check("len_latched_no_early", out_valid, 0);
    send(40, 2);
    check("len_latched_done", out_valid, 1);

    // Reset mid-frame discards the partial frame
    wait_in_ready();
    send(1, 4);
    send(2, 4);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_in_ready", in_ready, 1);
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    push(2, 1'b0);
    send(1, 2);
    send(1, 2);

    for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
